// File: rtl/wand_bus_arbiter_if.sv
// Bus bundle for wand_bus_arbiter: requester handshake, read-back data and
// the two wired-AND line pins. The master modport is the arbiter side; the
// slave modport is the requester/pad side.
interface wand_bus_arbiter_if #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned FRAME_BITS = 8
);
  logic [NREQ-1:0]            req;
  logic [NREQ*FRAME_BITS-1:0] tx_data;
  logic [NREQ-1:0]            gnt;
  logic                       busy;
  logic                       bus_o;
  logic                       bus_i;
  logic [FRAME_BITS-1:0]      rx_data;
  logic                       done;
  logic                       err;

  modport master (
    input  req, tx_data, bus_i,
    output gnt, busy, bus_o, rx_data, done, err
  );

  modport slave (
    output req, tx_data, bus_i,
    input  gnt, busy, bus_o, rx_data, done, err
  );
endinterface

// File: rtl/wand_bus_arbiter.sv
// Round-robin arbiter and MSB-first serializer for one shared wired-AND line.
// Each driven bit is read back from the resolved net; a released '1' that reads
// back as '0' is a collision and aborts the frame.
// Optional feature macro: COLLISION_RETRY_EN (retry a colliding frame up to
// MAX_RETRY times while keeping the grant).
module wand_bus_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  wand_bus_arbiter_if.master  bus
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(FRAME_BITS);
  localparam int unsigned MSB   = FRAME_BITS - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Elaboration-time parameter range check
  if (NREQ < 2 || NREQ > 8 || FRAME_BITS < 2 || MAX_RETRY > 255) begin : g_param_check
    $error("wand_bus_arbiter: parameter out of range");
  end

  state_t                r_state, w_state_nxt;
  logic [NREQ-1:0]       r_gnt, w_gnt_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_bus_o, w_bus_o_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic [FRAME_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [FRAME_BITS-1:0] r_rx, w_rx_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, w_rr_nxt;
  logic [PTR_W-1:0]      r_win, w_win_nxt;
  logic [CNT_W-1:0]      r_bitcnt, w_bitcnt_nxt;

  logic [FRAME_BITS-1:0] w_tx_word [NREQ];
  logic [PTR_W-1:0]      w_pick;
  logic                  w_pick_vld;
  int unsigned           w_idx;
  logic [PTR_W-1:0]      w_ptr_inc;
  logic                  w_collision;
  logic                  w_last_bit;
  logic                  w_retry_again;

  // Split the flat tx_data bus into per-requester words
  for (genvar g = 0; g < NREQ; g++) begin : g_tx
    assign w_tx_word[g] = bus.tx_data[g*FRAME_BITS +: FRAME_BITS];
  end

  // Round-robin pick: first active request at or after rr_ptr, wrapping
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_rr_ptr;
    w_idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_pick_vld && bus.req[PTR_W'(w_idx)]) begin
        w_pick_vld = 1'b1;
        w_pick     = PTR_W'(w_idx);
      end
    end
  end

  assign w_ptr_inc   = (r_win == PTR_W'(NREQ - 1)) ? '0 : r_win + PTR_W'(1);
  assign w_collision = (r_state == S_SHIFT) && r_shreg[MSB] && !bus.bus_i;
  assign w_last_bit  = (r_bitcnt == CNT_W'(FRAME_BITS - 1));

`ifdef COLLISION_RETRY_EN
  localparam int unsigned RTY_W = $clog2(MAX_RETRY + 2);
  logic [RTY_W-1:0] r_retry, w_retry_nxt;

  // r_retry holds the collisions seen so far in this frame
  assign w_retry_again = (r_retry <= RTY_W'(MAX_RETRY));

  // Per-frame collision counter
  always_ff @(posedge clk) begin
    if (!rst_n) r_retry <= '0;
    else        r_retry <= w_retry_nxt;
  end
`else
  assign w_retry_again = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_collision)     w_state_nxt = S_ERR;
        else if (w_last_bit) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = w_retry_again ? S_GRANT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything lands in registers
  always_comb begin
    w_gnt_nxt     = r_gnt;
    w_bus_o_nxt   = 1'b1;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_rx_data_nxt = r_rx_data;
    w_rr_nxt      = r_rr_ptr;
    w_win_nxt     = r_win;
    w_shreg_nxt   = r_shreg;
    w_rx_nxt      = r_rx;
    w_bitcnt_nxt  = r_bitcnt;
`ifdef COLLISION_RETRY_EN
    w_retry_nxt   = r_retry;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        if (w_pick_vld) begin
          w_win_nxt    = w_pick;
          w_gnt_nxt    = NREQ'(1) << w_pick;
          w_shreg_nxt  = w_tx_word[w_pick];
          w_bitcnt_nxt = '0;
`ifdef COLLISION_RETRY_EN
          w_retry_nxt  = '0;
`endif
        end
      end
      S_GRANT: w_bus_o_nxt = r_shreg[MSB];
      S_SHIFT: begin
        w_rx_nxt = {r_rx[MSB-1:0], bus.bus_i};
        if (w_collision) begin
          w_err_nxt = 1'b1;
`ifdef COLLISION_RETRY_EN
          w_retry_nxt = r_retry + RTY_W'(1);
`endif
        end else begin
          w_shreg_nxt  = {r_shreg[MSB-1:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          if (w_last_bit) begin
            w_done_nxt    = 1'b1;
            w_rx_data_nxt = w_rx_nxt;
          end else begin
            w_bus_o_nxt   = r_shreg[MSB-1];
          end
        end
      end
      S_DONE: begin
        w_gnt_nxt = '0;
        w_rr_nxt  = w_ptr_inc;
      end
      S_ERR: begin
        if (w_retry_again) begin
          w_shreg_nxt  = w_tx_word[r_win];
          w_bitcnt_nxt = '0;
        end else begin
          w_gnt_nxt = '0;
          w_rr_nxt  = w_ptr_inc;
        end
      end
      default: w_gnt_nxt = '0;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_bus_o   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rx_data <= '0;
      r_rr_ptr  <= '0;
      r_win     <= '0;
      r_shreg   <= '0;
      r_rx      <= '0;
      r_bitcnt  <= '0;
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_busy    <= w_busy_nxt;
      r_bus_o   <= w_bus_o_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_win     <= w_win_nxt;
      r_shreg   <= w_shreg_nxt;
      r_rx      <= w_rx_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.bus_o   = r_bus_o;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rx_data = r_rx_data;

endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Directed bench for wand_bus_arbiter (NREQ=4, FRAME_BITS=8). The line is
// modelled as the DUT drive ANDed with an optional foreign pull-down.
module tb_wand_bus_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned FB   = 8;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic force_low = 1'b0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  wand_bus_arbiter_if #(.NREQ(NREQ), .FRAME_BITS(FB)) bif ();

  assign bif.bus_i = bif.bus_o & ~force_low;

  wand_bus_arbiter #(
    .NREQ       (NREQ),
    .FRAME_BITS (FB),
    .MAX_RETRY  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one frame from its first IDLE cycle (req already applied) through the
  // IDLE cycle that follows DONE/ERR. coll_bit selects the shift cycle that gets
  // a foreign pull-down (-1 = none); next_req is applied in the first shift cycle.
  task automatic do_frame(input logic [3:0] exp_gnt, input logic [7:0] exp_word,
                          input int coll_bit, input logic [3:0] next_req);
    bit hit;
    hit = 1'b0;
    step();
    chk("grant_gnt",   32'(bif.gnt),   32'(exp_gnt));
    chk("grant_bus_o", 32'(bif.bus_o), 32'(1'b1));
    chk("grant_busy",  32'(bif.busy),  32'(1'b1));
    for (int i = 0; i < 8 && !hit; i++) begin
      step();
      chk("shift_bus_o", 32'(bif.bus_o), 32'(exp_word[7-i]));
      if (i == 0) bif.req = next_req;
      if (i == coll_bit) begin
        force_low = 1'b1;
        hit       = exp_word[7-i];
      end else begin
        force_low = 1'b0;
      end
    end
    step();
    force_low = 1'b0;
    if (hit) begin
      chk("err_pulse",  32'(bif.err),  32'(1'b1));
      chk("err_nodone", 32'(bif.done), 32'(1'b0));
      chk("err_gnt",    32'(bif.gnt),  32'(exp_gnt));
    end else begin
      chk("done_pulse", 32'(bif.done),    32'(1'b1));
      chk("done_noerr", 32'(bif.err),     32'(1'b0));
      chk("done_rx",    32'(bif.rx_data), 32'(exp_word));
      chk("done_gnt",   32'(bif.gnt),     32'(exp_gnt));
    end
    step();
    chk("post_gnt",  32'(bif.gnt),  32'(4'b0000));
    chk("post_busy", 32'(bif.busy), 32'(1'b0));
    chk("post_done", 32'(bif.done), 32'(1'b0));
    chk("post_err",  32'(bif.err),  32'(1'b0));
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bif.req     = '0;
    bif.tx_data = {8'h3C, 8'h96, 8'hA5, 8'hFF};
    rst_n       = 1'b0;
    step();
    step();
    chk("rst_gnt",   32'(bif.gnt),     32'(4'b0000));
    chk("rst_busy",  32'(bif.busy),    32'(1'b0));
    chk("rst_bus_o", 32'(bif.bus_o),   32'(1'b1));
    chk("rst_done",  32'(bif.done),    32'(1'b0));
    chk("rst_err",   32'(bif.err),     32'(1'b0));
    chk("rst_rx",    32'(bif.rx_data), 32'(8'h00));
    rst_n = 1'b1;

    // Single requester 1 sending A5; req dropped mid-frame
    bif.req = 4'b0010;
    do_frame(4'b0010, 8'hA5, -1, 4'b0000);
    step();
    chk("idle_hold_gnt",  32'(bif.gnt),  32'(4'b0000));
    chk("idle_hold_busy", 32'(bif.busy), 32'(1'b0));

    // All request, rr_ptr=2: order 2,3,0,1; a pulled-down '0' bit is harmless
    bif.req = 4'b1111;
    do_frame(4'b0100, 8'h96, 1,  4'b1111);
    do_frame(4'b1000, 8'h3C, -1, 4'b1111);
    do_frame(4'b0001, 8'hFF, -1, 4'b1111);
    do_frame(4'b0010, 8'hA5, -1, 4'b0000);

`ifdef COLLISION_RETRY_EN
    // Collision on every attempt: four err pulses, then the grant drops
    bif.req = 4'b0001;
    for (int a = 0; a < 4; a++) begin
      step();
      chk("rty_grant_gnt", 32'(bif.gnt), 32'(4'b0001));
      step();
      force_low = 1'b1;
      chk("rty_bus_o", 32'(bif.bus_o), 32'(1'b1));
      step();
      force_low = 1'b0;
      if (a == 3) bif.req = 4'b0000;
      chk("rty_err",  32'(bif.err),  32'(1'b1));
      chk("rty_gnt",  32'(bif.gnt),  32'(4'b0001));
      chk("rty_done", 32'(bif.done), 32'(1'b0));
    end
    step();
    chk("rty_drop_gnt",  32'(bif.gnt),  32'(4'b0000));
    chk("rty_drop_busy", 32'(bif.busy), 32'(1'b0));

    // Collision only on the first attempt, then a clean frame
    bif.req = 4'b0001;
    step();
    step();
    force_low = 1'b1;
    step();
    force_low = 1'b0;
    bif.req   = 4'b0000;
    chk("rty1_err", 32'(bif.err), 32'(1'b1));
    step();
    chk("rty1_regrant", 32'(bif.gnt),   32'(4'b0001));
    chk("rty1_bus_o",   32'(bif.bus_o), 32'(1'b1));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rty1_shift", 32'(bif.bus_o), 32'(1'b1));
    end
    step();
    chk("rty1_done", 32'(bif.done),    32'(1'b1));
    chk("rty1_rx",   32'(bif.rx_data), 32'(8'hFF));
    step();
    chk("rty1_idle", 32'(bif.gnt), 32'(4'b0000));
`else
    // Requester 0 sends FF, pulled low in the third shift cycle
    bif.req = 4'b0001;
    do_frame(4'b0001, 8'hFF, 2, 4'b0000);
    chk("coll_rx_kept", 32'(bif.rx_data), 32'(8'hA5));
`endif

    // rr_ptr now 1: requester 1 wins over requester 0
    bif.req = 4'b0011;
    do_frame(4'b0010, 8'hA5, -1, 4'b1111);

    // Requester 2 granted, reset asserted at bit 4
    step();
    chk("rst_mid_grant", 32'(bif.gnt), 32'(4'b0100));
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_gnt",   32'(bif.gnt),   32'(4'b0000));
    chk("rst_mid_bus_o", 32'(bif.bus_o), 32'(1'b1));
    chk("rst_mid_busy",  32'(bif.busy),  32'(1'b0));
    chk("rst_mid_done",  32'(bif.done),  32'(1'b0));
    chk("rst_mid_err",   32'(bif.err),   32'(1'b0));
    rst_n = 1'b1;

    // Round robin from rr_ptr=0 after reset: 0,1,2,3
    do_frame(4'b0001, 8'hFF, -1, 4'b1111);
    do_frame(4'b0010, 8'hA5, -1, 4'b1111);
    do_frame(4'b0100, 8'h96, -1, 4'b1111);
    do_frame(4'b1000, 8'h3C, -1, 4'b0000);

    // Request withdrawn mid-frame still completes, then stays idle
    bif.req = 4'b0100;
    do_frame(4'b0100, 8'h96, -1, 4'b0000);
    step();
    step();
    chk("wd_idle_gnt",  32'(bif.gnt),  32'(4'b0000));
    chk("wd_idle_busy", 32'(bif.busy), 32'(1'b0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wand_bus_arbiter.md
Name: wand_bus_arbiter

Overview:
- Round-robin arbiter and serializer for a single shared wired-AND (open-drain) line.
- Up to NREQ requesters each present a FRAME_BITS word. The block grants one requester at a time and shifts its word MSB-first onto the line.
- Each bit is read back from the resolved wired-AND line to detect collisions, because a released '1' can be pulled to '0' by a foreign driver.
- Sits between local requesters and the pad-level wand net. bus_o feeds the wand driver; bus_i is the resolved net value.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FRAME_BITS, 8, bits per transfer (>=2).
- MAX_RETRY, 3, collision retries per frame; used only when COLLISION_RETRY_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  request per requester; level, sampled only in IDLE.
- tx_data  in  NREQ*FRAME_BITS  word for requester i at bits [i*FRAME_BITS +: FRAME_BITS].
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high in any state other than IDLE.
- bus_o  out  1  line drive: 0 pulls the line low; 1 releases it.
- bus_i  in  1  resolved wired-AND line value, sampled on clk.
- rx_data  out  FRAME_BITS  bits read back from the line; valid while done=1.
- done  out  1  one-cycle pulse: frame completed without collision.
- err  out  1  one-cycle pulse: frame aborted on collision.

Behaviour:
- Reset values (rst_n low at a clk edge): state=IDLE, gnt=0, busy=0, bus_o=1, rx_data=0, done=0, err=0, rr_ptr=0, bitcnt=0.
- Reset mid-transfer aborts at that edge: line released, no done/err pulse.
- States: IDLE, GRANT, SHIFT, DONE, ERR. All outputs are registered.
- IDLE, transition:
  - bus_o=1, gnt=0.
  - If req!=0, the winner is the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Next edge: gnt=onehot(winner), shreg<=winner's tx_data slice, bitcnt=0, state=GRANT.
- IDLE, while waiting: if req==0, stay in IDLE.
- GRANT: exactly one cycle with bus_o=1 (bus turnaround). Next edge: state=SHIFT.
- SHIFT, line drive: bus_o=shreg[MSB].
- SHIFT, at each edge:
  - rx shifts in bus_i.
  - If shreg[MSB]==1 and bus_i==0, that is a collision: state=ERR.
  - Otherwise shreg shifts left and bitcnt increments.
  - When bitcnt==FRAME_BITS-1 with no collision, state=DONE.
  - Driving 0 never collides.
- DONE: done=1 and rx_data=captured word for one cycle, gnt held, bus_o=1. Next edge: gnt=0, rr_ptr=(winner+1) mod NREQ, state=IDLE.
- ERR: err=1 for one cycle, gnt held, bus_o=1. Next edge: gnt=0, rr_ptr=(winner+1) mod NREQ, state=IDLE. rx_data is not updated.
- Latency: req first seen in IDLE at cycle 0 gives GRANT at cycle 1, SHIFT at cycles 2..FRAME_BITS+1, and done at cycle FRAME_BITS+2. For FRAME_BITS=8, done is high in cycle 10.
- Minimum spacing between frames is one IDLE cycle.
- Once a frame is granted, req and tx_data are ignored until return to IDLE. Dropping req mid-frame does not abort the frame.
- Simultaneous requests resolve by round-robin only. No requester is starved: worst-case wait is NREQ-1 frames.
- rr_ptr wraps from NREQ-1 to 0.
- busy=1 in GRANT, SHIFT, DONE and ERR.

Optional Feature:
- Macro: COLLISION_RETRY_EN.
- Defined:
  - ERR does not release the grant. The next edge returns to GRANT with the same winner, shreg reloaded from its current tx_data, and bitcnt=0.
  - err pulses on each collision. A per-frame retry counter increments on each collision.
  - On the collision that exceeds MAX_RETRY, the block behaves as undefined-macro ERR: grant dropped, rr_ptr advanced.
  - The retry counter clears on entry from IDLE.
- Undefined: ERR behaves as described in Behaviour; no retry counter is synthesized.

Test Plan:
- Single requester: req=4'b0010, tx_data slice1=8'hA5, bus_i=bus_o → gnt=4'b0010 from cycle 1; bus_o serial 1,0,1,0,0,1,0,1; done in cycle 10; rx_data=8'hA5; rr_ptr=2.
- Round robin: req=4'b1111 held for four frames starting with rr_ptr=0 → grants in order 0,1,2,3; each frame done; exactly one IDLE cycle between frames.
- Collision: requester 0 sends 8'hFF; bench forces bus_i=0 during the 3rd SHIFT cycle → err pulse in the next cycle; no done; gnt cleared after ERR; rr_ptr=1.
- Retry (COLLISION_RETRY_EN, MAX_RETRY=3): collision forced on every attempt → four err pulses, then grant dropped. Same frame with collision only on the first attempt → one err, then done, rx_data correct.
- Reset mid-SHIFT: rst_n low at bit 4 → next edge gnt=0, bus_o=1, busy=0, no done/err; after release, the first frame is granted from rr_ptr=0.
- Req withdrawn mid-frame: req drops to 0 during SHIFT → frame still completes with done; block stays in IDLE afterwards.
